// File: rtl/spu_pkg.sv
// Shared types and helpers for the SPU adder arbiter.
//   DEF_*     : default widths/sizes used by spu_adder_arbiter parameters
//   spu_op_t  : one requester's operand bundle {D,C,B,A}
//   rsp_t     : response FIFO payload {id,sum}
//   rr_pick   : round-robin one-hot pick of the first valid at/after ptr
package spu_pkg;

  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_AB_W      = 4;
  localparam int unsigned DEF_CD_W      = 3;
  localparam int unsigned DEF_SUM_W     = 8;
  localparam int unsigned DEF_RSP_DEPTH = 4;
  localparam int unsigned MAX_NREQ      = 8;
  localparam int unsigned MAX_ID_W      = 3;

  typedef struct packed {
    logic [DEF_CD_W-1:0] d;
    logic [DEF_CD_W-1:0] c;
    logic [DEF_AB_W-1:0] b;
    logic [DEF_AB_W-1:0] a;
  } spu_op_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0]  id;
    logic [DEF_SUM_W-1:0] sum;
  } rsp_t;

  // One-hot of the first set bit of valid, scanning cyclically from ptr over n slots.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                  input logic [MAX_ID_W-1:0] ptr,
                                                  input int unsigned n);
    logic [MAX_NREQ-1:0] grant;
    logic                found;
    int unsigned         idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < n) begin
        idx = (32'(ptr) + i) % n;
        if (!found && valid[3'(idx)]) begin
          grant[3'(idx)] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/spu_add4_pipe.sv
// Two-stage 4-operand adder with valid/id sideband, no backpressure.
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_id     : issue strobe and requester tag
//   in_a..in_d          : operands
//   s1_valid            : stage-1 occupancy (used for credit accounting)
//   out_valid, out_id   : stage-2 result strobe and tag
//   out_sum             : A+B+C+D zero-extended to SUM_W
module spu_add4_pipe
  import spu_pkg::*;
#(
  parameter int unsigned ID_W  = 2,
  parameter int unsigned AB_W  = DEF_AB_W,
  parameter int unsigned CD_W  = DEF_CD_W,
  parameter int unsigned SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ID_W-1:0]  in_id,
  input  logic [AB_W-1:0]  in_a,
  input  logic [AB_W-1:0]  in_b,
  input  logic [CD_W-1:0]  in_c,
  input  logic [CD_W-1:0]  in_d,
  output logic             s1_valid,
  output logic             out_valid,
  output logic [ID_W-1:0]  out_id,
  output logic [SUM_W-1:0] out_sum
);

  logic [ID_W-1:0] s1_id;
  logic [AB_W-1:0] s1_a, s1_b;
  logic [CD_W-1:0] s1_c, s1_d;

  // Stage 1 captures operands, stage 2 captures the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_c      <= '0;
      s1_d      <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_sum   <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_id     <= in_id;
      s1_a      <= in_a;
      s1_b      <= in_b;
      s1_c      <= in_c;
      s1_d      <= in_d;
      out_valid <= s1_valid;
      out_id    <= s1_id;
      out_sum   <= SUM_W'(s1_a) + SUM_W'(s1_b) + SUM_W'(s1_c) + SUM_W'(s1_d);
    end
  end

endmodule

// File: rtl/spu_adder_arbiter.sv
// Round-robin arbiter sharing one pipelined 4-operand adder among NREQ requesters.
// Results return in acceptance order through a fall-through response FIFO;
// issue is credit-limited so the FIFO can never overflow under consumer stall.
//   clk, rst_n            : clock, async active-low reset
//   en                    : issue enable (in-flight ops still complete when low)
//   req_valid/req_ready   : per-requester handshake, req_ready one-hot
//   req_ops               : per-requester {D,C,B,A}, requester i at slice i
//   rsp_valid/rsp_ready   : FIFO head handshake
//   rsp_id, rsp_sum       : head tag and result
//   busy                  : op in flight or FIFO non-empty
//   stats_clr, grant_cnt  : per-requester grant counters
// Build option: define SPU_STATS_EN to instantiate saturating grant counters;
// otherwise grant_cnt is tied to zero and stats_clr is ignored.
module spu_adder_arbiter
  import spu_pkg::*;
#(
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned AB_W      = DEF_AB_W,
  parameter int unsigned CD_W      = DEF_CD_W,
  parameter int unsigned SUM_W     = DEF_SUM_W,
  parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ*(2*AB_W+2*CD_W)-1:0]     req_ops,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(NREQ)-1:0]             rsp_id,
  output logic [SUM_W-1:0]                    rsp_sum,
  output logic                                busy,
  input  logic                                stats_clr,
  output logic [NREQ*16-1:0]                  grant_cnt
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned OP_W  = 2*AB_W + 2*CD_W;
  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CR_W  = CNT_W + 1;

  logic                  arm_q;
  logic [ID_W-1:0]       rr_ptr;
  logic [MAX_NREQ-1:0]   pick;
  logic                  unused_pick;
  logic                  credit_ok;
  logic [NREQ-1:0]       hs;
  logic                  hs_any;
  logic [ID_W-1:0]       gsel;
  logic [OP_W-1:0]       op_sel;

  logic                  s1_v;
  logic                  s2_v;
  logic [ID_W-1:0]       s2_id;
  logic [SUM_W-1:0]      s2_sum;

  logic [ID_W-1:0]       mem_id  [RSP_DEPTH];
  logic [SUM_W-1:0]      mem_sum [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  push;
  logic                  pop;

  // Holds off grants until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arm_q <= 1'b0;
    else        arm_q <= 1'b1;
  end

  // Outstanding ops (FIFO + pipe) must stay below depth; same-cycle pops are not counted.
  always_comb begin
    credit_ok = (CR_W'(fifo_cnt) + CR_W'(s1_v) + CR_W'(s2_v)) < CR_W'(RSP_DEPTH);
  end

  // Combinational round-robin grant.
  always_comb begin
    pick        = rr_pick(MAX_NREQ'(req_valid), MAX_ID_W'(rr_ptr), NREQ);
    unused_pick = ^pick;
    req_ready   = '0;
    if (arm_q && en && credit_ok) req_ready = pick[NREQ-1:0];
  end

  // Handshake decode and operand mux.
  always_comb begin
    hs     = req_valid & req_ready;
    hs_any = |hs;
    gsel   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (hs[i]) gsel = ID_W'(i);
    end
    op_sel = req_ops[gsel*OP_W +: OP_W];
  end

  // Pointer moves past the winner only on an actual handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (hs_any) begin
      rr_ptr <= (gsel == ID_W'(NREQ - 1)) ? '0 : gsel + ID_W'(1);
    end
  end

  spu_add4_pipe #(
    .ID_W  (ID_W),
    .AB_W  (AB_W),
    .CD_W  (CD_W),
    .SUM_W (SUM_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (hs_any),
    .in_id     (gsel),
    .in_a      (op_sel[AB_W-1:0]),
    .in_b      (op_sel[2*AB_W-1:AB_W]),
    .in_c      (op_sel[2*AB_W+CD_W-1:2*AB_W]),
    .in_d      (op_sel[OP_W-1:2*AB_W+CD_W]),
    .s1_valid  (s1_v),
    .out_valid (s2_v),
    .out_id    (s2_id),
    .out_sum   (s2_sum)
  );

  always_comb begin
    push = s2_v;
    pop  = rsp_valid && rsp_ready;
  end

  // Response storage; a push at full lands in the slot the same-cycle pop vacates.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]  <= s2_id;
      mem_sum[wr_ptr] <= s2_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Fall-through head; payload forced to zero when empty so reset reads as zero.
  always_comb begin
    rsp_valid = (fifo_cnt != '0);
    rsp_id    = rsp_valid ? mem_id[rd_ptr]  : '0;
    rsp_sum   = rsp_valid ? mem_sum[rd_ptr] : '0;
    busy      = s1_v || s2_v || rsp_valid;
  end

`ifdef SPU_STATS_EN
  logic [15:0] cnt_q [NREQ];

  // Saturating per-requester grant counters; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (stats_clr) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (hs[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) grant_cnt[16*i +: 16] = cnt_q[i];
  end
`else
  logic unused_stats_clr;

  always_comb begin
    grant_cnt        = '0;
    unused_stats_clr = stats_clr;
  end
`endif

endmodule

// File: tb/tb_spu_adder_arbiter.sv
module tb_spu_adder_arbiter;
  import spu_pkg::*;

  localparam int NREQ  = 4;
  localparam int OP_W  = 14;
  localparam int DEPTH = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OP_W-1:0] req_ops;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [7:0]           rsp_sum;
  logic                 busy;
  logic                 stats_clr;
  logic [NREQ*16-1:0]   grant_cnt;

  spu_adder_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ops   (req_ops),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy),
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sum;
    int vis;
  } exp_t;

  // Reference model: outstanding ops, arrival-ordered results, plain counters.
  int   n_vec;
  int   n_err;
  int   edges;
  bit   armed;
  int   ptr;
  int   outstanding;
  exp_t q[$];
  int   gcnt[NREQ];
  int   hs_g;
  int   hs_sum;
  bit   pop_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int op_sum(input int g);
    spu_op_t op;
    op = req_ops[g*OP_W +: OP_W];
    return int'(op.a) + int'(op.b) + int'(op.c) + int'(op.d);
  endfunction

  function automatic logic [63:0] exp_gc();
    logic [63:0] v;
    v = '0;
`ifdef SPU_STATS_EN
    for (int i = 0; i < NREQ; i++) v[16*i +: 16] = 16'(gcnt[i]);
`endif
    return v;
  endfunction

  // Compare DUT outputs with the model for the current (stable) inputs.
  task automatic eval_cycle();
    logic [NREQ-1:0] er;
    bit vis;
    er   = '0;
    hs_g = -1;
    if (armed && en && outstanding < DEPTH) begin
      for (int i = 0; i < NREQ; i++) begin
        int idx;
        idx = (ptr + i) % NREQ;
        if (req_valid[idx] && hs_g < 0) begin
          er[idx] = 1'b1;
          hs_g    = idx;
        end
      end
    end
    check("req_ready", 64'(req_ready), 64'(er));
    vis = (q.size() > 0) && (q[0].vis <= edges);
    check("rsp_valid", 64'(rsp_valid), 64'(vis));
    if (vis) begin
      check("rsp_id",  64'(rsp_id),  64'(q[0].id));
      check("rsp_sum", 64'(rsp_sum), 64'(q[0].sum));
    end
    check("busy", 64'(busy), 64'(outstanding > 0));
    check("grant_cnt", grant_cnt, exp_gc());
    pop_e  = vis && rsp_ready;
    hs_sum = (hs_g >= 0) ? op_sum(hs_g) : 0;
  endtask

  task automatic update_model();
    exp_t e;
    edges++;
    if (pop_e) begin
      void'(q.pop_front());
      outstanding--;
    end
    if (hs_g >= 0) begin
      e.id  = hs_g;
      e.sum = hs_sum;
      e.vis = edges + 2;
      q.push_back(e);
      outstanding++;
      ptr = (hs_g + 1) % NREQ;
      if (gcnt[hs_g] < 65535) gcnt[hs_g]++;
    end
    if (stats_clr) begin
      for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    end
    armed = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(input int pv, input int pr, input int pe, input bit clr_ok);
    spu_op_t op;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = ($urandom_range(99) < pv);
      op = spu_op_t'($urandom);
      if ($urandom_range(7) == 0) op = '{d: 3'd7, c: 3'd7, b: 4'd15, a: 4'd15};
      req_ops[i*OP_W +: OP_W] = op;
    end
    rsp_ready = ($urandom_range(99) < pr);
    en        = ($urandom_range(99) < pe);
    stats_clr = clr_ok && ($urandom_range(63) == 0);
  endtask

  task automatic model_clear();
    q.delete();
    outstanding = 0;
    ptr         = 0;
    armed       = 1'b0;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
  endtask

  // Async reset pulse between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_id",    64'(rsp_id),    64'(0));
    check("rst_rsp_sum",   64'(rsp_sum),   64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_grant_cnt", grant_cnt,      64'(0));
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    spu_op_t op1;
    n_vec = 0;
    n_err = 0;
    edges = 0;
    rst_n = 1'b0;
    en = 1'b0;
    req_valid = '0;
    req_ops = '0;
    rsp_ready = 1'b0;
    stats_clr = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Single op from requester 2 with maximal operands (sum 44).
    op1 = '{d: 3'd7, c: 3'd7, b: 4'd15, a: 4'd15};
    en = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_ops[2*OP_W +: OP_W] = op1;
    step();
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) step();

    // All requesters continuously valid, free-flowing consumer.
    for (int i = 0; i < 40; i++) begin
      drive(100, 100, 100, 1'b0);
      step();
    end

    // Consumer stall fills the credit budget, then drains.
    for (int i = 0; i < 10; i++) begin
      drive(100, 0, 100, 1'b0);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      drive(100, 100, 100, 1'b0);
      step();
    end

    // en drops after issue; in-flight results still delivered.
    for (int i = 0; i < 2; i++) begin
      drive(100, 100, 100, 1'b0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(100, 100, 0, 1'b0);
      step();
    end

    // Randomized mixes of request density, consumer stall and enable.
    for (int k = 0; k < 6; k++) begin
      int pv, pr, pe;
      pv = (k % 3 == 0) ? 30 : ((k % 3 == 1) ? 70 : 100);
      pr = (k < 3) ? 50 : 85;
      pe = (k == 2) ? 60 : 95;
      for (int i = 0; i < 250; i++) begin
        drive(pv, pr, pe, 1'b1);
        step();
      end
    end

    // Reset pulse with traffic in flight, then resume.
    for (int i = 0; i < 6; i++) begin
      drive(100, 30, 100, 1'b0);
      step();
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive(60, 60, 90, 1'b1);
      step();
    end

    // Long run of grants to requester 1 exercises counter saturation when enabled.
    en = 1'b1;
    rsp_ready = 1'b1;
    stats_clr = 1'b0;
    req_valid = 4'b0010;
`ifdef SPU_STATS_EN
    for (int i = 0; i < 70000; i++) step();
`else
    for (int i = 0; i < 200; i++) step();
`endif
    req_valid = '0;
    step();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
